// File: rtl/fader_pkg.sv
// Shared parameters, complex coefficient type and Q1.15 round/saturate helper
// for the fading-coefficient apply path.
package fader_pkg;

    localparam int NCHAN  = 32;
    localparam int CHAN_W = 5;
    localparam int DW     = 16;

    // Field names re/im because "real" is a reserved word.
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    localparam logic signed [DW-1:0] Q15_ONE    = 16'sh7FFF;
    localparam cplx_t                COEF_RESET = {Q15_ONE, {DW{1'b0}}};

    localparam logic signed [2*DW:0] ROUND_BIAS = (2*DW+1)'(1 << (DW-2));
    localparam logic signed [2*DW:0] ACC_MAX    = (2*DW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [2*DW:0] ACC_MIN    = -((2*DW+1)'(1 << (DW-1)));

    // Round half up, drop the duplicated Q1.15 sign bit, clamp to DW bits.
    function automatic logic signed [DW-1:0] roundSat(input logic signed [2*DW:0] acc);
        logic signed [2*DW:0] rounded;
        logic signed [2*DW:0] shifted;
        rounded = acc + ROUND_BIAS;
        shifted = rounded >>> (DW-1);
        if (shifted > ACC_MAX) begin
            return ACC_MAX[DW-1:0];
        end else if (shifted < ACC_MIN) begin
            return ACC_MIN[DW-1:0];
        end
        return shifted[DW-1:0];
    endfunction

endpackage

// File: rtl/cmult_q15.sv
// Two-stage pipelined Q1.15 complex multiply (a+jb)(c+jd) with round and
// saturate; all stages advance only while i_en is high.
module cmult_q15
    import fader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [CHAN_W-1:0]    i_chan,
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    input  logic signed [DW-1:0] i_c,
    input  logic signed [DW-1:0] i_d,
    output logic                 o_valid,
    output logic [CHAN_W-1:0]    o_chan,
    output logic signed [DW-1:0] o_re,
    output logic signed [DW-1:0] o_im
);

    logic                   r_p_valid;
    logic [CHAN_W-1:0]      r_p_chan;
    logic signed [2*DW-1:0] r_ac;
    logic signed [2*DW-1:0] r_bd;
    logic signed [2*DW-1:0] r_ad;
    logic signed [2*DW-1:0] r_bc;

    logic signed [2*DW:0]   w_re_acc;
    logic signed [2*DW:0]   w_im_acc;

    logic                   r_valid;
    logic [CHAN_W-1:0]      r_chan;
    logic signed [DW-1:0]   r_re;
    logic signed [DW-1:0]   r_im;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_valid <= 1'b0;
            r_p_chan  <= '0;
            r_ac      <= '0;
            r_bd      <= '0;
            r_ad      <= '0;
            r_bc      <= '0;
        end else if (i_en) begin
            r_p_valid <= i_valid;
            r_p_chan  <= i_chan;
            r_ac      <= i_a * i_c;
            r_bd      <= i_b * i_d;
            r_ad      <= i_a * i_d;
            r_bc      <= i_b * i_c;
        end
    end

    // One guard bit: (-1)(-1) + (-1)(-1) = +2 must not wrap before saturation.
    assign w_re_acc = {r_ac[2*DW-1], r_ac} - {r_bd[2*DW-1], r_bd};
    assign w_im_acc = {r_ad[2*DW-1], r_ad} + {r_bc[2*DW-1], r_bc};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_re    <= '0;
            r_im    <= '0;
        end else if (i_en) begin
            r_valid <= r_p_valid;
            r_chan  <= r_p_chan;
            r_re    <= roundSat(w_re_acc);
            r_im    <= roundSat(w_im_acc);
        end
    end

    assign o_valid = r_valid;
    assign o_chan  = r_chan;
    assign o_re    = r_re;
    assign o_im    = r_im;

endmodule

// File: rtl/fader_apply.sv
// Double-banked per-channel fading coefficients applied to a channelised
// complex sample stream through a 3-stage multiply pipeline.
module fader_apply
    import fader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              coef_start,
    input  logic              coef_dv,
    input  logic [CHAN_W-1:0] coef_chan,
    input  logic [DW-1:0]     coef_real,
    input  logic [DW-1:0]     coef_imag,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CHAN_W-1:0] s_chan,
    input  logic [DW-1:0]     s_real,
    input  logic [DW-1:0]     s_imag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CHAN_W-1:0] m_chan,
    output logic [DW-1:0]     m_real,
    output logic [DW-1:0]     m_imag,
    output logic              bank_swap,
    output logic              coef_err
);

    cplx_t             r_shadow [NCHAN];
    cplx_t             r_active [NCHAN];
    logic [NCHAN-1:0]  r_mask;
    logic [NCHAN-1:0]  w_mask_next;
    logic              r_err;
    logic              w_full;
    logic              w_en;

    logic              r_s1_valid;
    logic [CHAN_W-1:0] r_s1_chan;
    cplx_t             r_s1_x;
    cplx_t             r_s1_c;

    // The swap happens at the end of the cycle in which the mask reads full.
    assign w_full    = &r_mask;
    assign bank_swap = w_full;
    assign coef_err  = r_err;

    assign w_en    = m_ready || !m_valid;
    assign s_ready = w_en;

    always_comb begin
        w_mask_next = r_mask;
        if (w_full || coef_start) begin
            w_mask_next = '0;
        end
        if (coef_dv) begin
            w_mask_next[coef_chan] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                r_shadow[i] <= COEF_RESET;
                r_active[i] <= COEF_RESET;
            end
        end else begin
            if (coef_dv) begin
                r_shadow[coef_chan] <= cplx_t'({coef_real, coef_imag});
            end
            if (w_full) begin
                r_active <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_err  <= 1'b0;
        end else begin
            r_mask <= w_mask_next;
            if (coef_start && (r_mask != '0) && !w_full) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_chan  <= '0;
            r_s1_x     <= '0;
            r_s1_c     <= COEF_RESET;
        end else if (w_en) begin
            r_s1_valid <= s_valid;
            r_s1_chan  <= s_chan;
            r_s1_x     <= cplx_t'({s_real, s_imag});
            r_s1_c     <= r_active[s_chan];
        end
    end

    cmult_q15 u_cmult (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_en),
        .i_valid (r_s1_valid),
        .i_chan  (r_s1_chan),
        .i_a     (r_s1_x.re),
        .i_b     (r_s1_x.im),
        .i_c     (r_s1_c.re),
        .i_d     (r_s1_c.im),
        .o_valid (m_valid),
        .o_chan  (m_chan),
        .o_re    (m_real),
        .o_im    (m_imag)
    );

endmodule
